pipe_reg_file: RTL and testbench

Parametrised, clocked general-purpose register file for the pipelined core. It replaces the single-cycle combinational-write register file. It adds a synchronous write port, a configurable number of combinational read ports, and an optional write-to-read bypass. A per-register pending scoreboard lets decode stall on read-after-write hazards. It sits between decode (read/allocate) and writeback (write/release).

---
 rtl/pipe_reg_file_pkg.sv | 18 +
 rtl/pipe_reg_file_reg_scoreboard.sv | 60 ++++++
 rtl/pipe_reg_file.sv | 93 +++++++++
 tb/tb_pipe_reg_file.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_reg_file_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// pipe_reg_file_pkg : shared types and defaults for the register file
// Rev 1.0
// ---------------------------------------------------------------
package pipe_reg_file_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_NUM_RD   = 2;

    typedef logic [DEF_DATA_W-1:0]           word_t;
    typedef logic [$clog2(DEF_NUM_REGS)-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage
`default_nettype wire

// File: rtl/pipe_reg_file_reg_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------
// reg_scoreboard : per-register pending bits with flush/alloc/write priority
// Rev 1.0
// ---------------------------------------------------------------
module reg_scoreboard
    import pipe_reg_file_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter bit ZERO_REG = 1'b1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic                           alloc_en,
    input  logic [ADDR_W-1:0]              alloc_addr,
    input  logic                           flush,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
    output logic [NUM_RD-1:0]              rd_pending,
    output logic                           any_pending
);

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_pending_nxt;

    // Flush beats alloc, alloc beats write-release on the same register.
    always_comb begin
        w_pending_nxt = r_pending;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_en && (wr_addr == ADDR_W'(i)))
                w_pending_nxt[i] = 1'b0;
            if (alloc_en && !flush && (alloc_addr == ADDR_W'(i)))
                w_pending_nxt[i] = 1'b1;
        end
        if (flush)
            w_pending_nxt = '0;
        if (ZERO_REG)
            w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pending <= '0;
        else
            r_pending <= w_pending_nxt;
    end

    assign any_pending = |r_pending;

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_pend
            assign rd_pending[p] = r_pending[rd_addr[p]];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/pipe_reg_file.sv
`default_nettype none
// ---------------------------------------------------------------
// pipe_reg_file : clocked register file with bypass and pending scoreboard
// Rev 1.0
// ---------------------------------------------------------------
module pipe_reg_file
    import pipe_reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
    output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
    output logic [NUM_RD-1:0]              rd_pending,
    input  logic                           wr_en,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [DATA_W-1:0]              wr_data,
    input  logic                           alloc_en,
    input  logic [ADDR_W-1:0]              alloc_addr,
    input  logic                           flush,
    output logic                           any_pending
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [NUM_RD-1:0] w_sb_pending;
    logic              w_wr_ok;
    logic              w_alloc_ok;

    assign w_wr_ok    = wr_en    && !(ZERO_REG && (wr_addr    == '0));
    assign w_alloc_ok = alloc_en && !(ZERO_REG && (alloc_addr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= '0;
        end else if (w_wr_ok) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (w_wr_ok),
        .wr_addr     (wr_addr),
        .alloc_en    (w_alloc_ok),
        .alloc_addr  (alloc_addr),
        .flush       (flush),
        .rd_addr     (rd_addr),
        .rd_pending  (w_sb_pending),
        .any_pending (any_pending)
    );

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
            logic [DATA_W-1:0] w_data;
            logic              w_pend;
            logic              w_zero;
            logic              w_byp;

            assign w_zero = ZERO_REG && (rd_addr[p] == '0);
            // Gated by rst_n so a write presented during reset cannot leak out.
            assign w_byp  = BYPASS && rst_n && wr_en && (wr_addr == rd_addr[p]);

            always_comb begin
                w_data = r_regs[rd_addr[p]];
                w_pend = w_sb_pending[p];
                if (w_zero) begin
                    w_data = '0;
                    w_pend = 1'b0;
                end else if (w_byp) begin
                    w_data = wr_data;
                    w_pend = 1'b0;
                end
            end

            assign rd_data[p]    = w_data;
            assign rd_pending[p] = w_pend;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipe_reg_file.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_pipe_reg_file : two configurations (default, and 4-port/64-bit/no-bypass)
// Rev 1.0
// ---------------------------------------------------------------
module tb_pipe_reg_file;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [4:0]        wr_addr;
    logic [63:0]       wr_data;
    logic              alloc_en;
    logic [4:0]        alloc_addr;
    logic              flush;

    logic [1:0][4:0]   rd_addr_a;
    logic [1:0][31:0]  rd_data_a;
    logic [1:0]        rd_pend_a;
    logic              any_a;

    logic [3:0][4:0]   rd_addr_b;
    logic [3:0][63:0]  rd_data_b;
    logic [3:0]        rd_pend_b;
    logic              any_b;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] m_regs [32];
    logic        m_pend [32];

    always #5 clk = ~clk;

    pipe_reg_file dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr     (rd_addr_a),
        .rd_data     (rd_data_a),
        .rd_pending  (rd_pend_a),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data[31:0]),
        .alloc_en    (alloc_en),
        .alloc_addr  (alloc_addr),
        .flush       (flush),
        .any_pending (any_a)
    );

    pipe_reg_file #(
        .DATA_W (64),
        .NUM_RD (4),
        .BYPASS (1'b0)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr     (rd_addr_b),
        .rd_data     (rd_data_b),
        .rd_pending  (rd_pend_b),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .alloc_en    (alloc_en),
        .alloc_addr  (alloc_addr),
        .flush       (flush),
        .any_pending (any_b)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic        ae;
        logic [4:0]  aa;
        logic        fl;
        logic [4:0]  ra;
        logic [31:0] exp_d;
        logic        exp_p;
        logic        exp_any;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        alloc_en   = 1'b0;
        alloc_addr = '0;
        flush      = 1'b0;
    endtask

    task automatic set_rd_all(input logic [4:0] a);
        for (int p = 0; p < 2; p++) rd_addr_a[p] = a;
        for (int p = 0; p < 4; p++) rd_addr_b[p] = a;
    endtask

    task automatic randomize_inputs();
        wr_en      = 1'($urandom_range(1));
        wr_addr    = ($urandom_range(1) == 1) ? 5'($urandom_range(7)) : 5'($urandom_range(31));
        wr_data    = {$urandom, $urandom};
        alloc_en   = 1'($urandom_range(1));
        alloc_addr = ($urandom_range(1) == 1) ? 5'($urandom_range(7)) : 5'($urandom_range(31));
        flush      = ($urandom_range(15) == 0);
        for (int p = 0; p < 2; p++) rd_addr_a[p] = ($urandom_range(1) == 1) ? wr_addr : 5'($urandom_range(31));
        for (int p = 0; p < 4; p++) rd_addr_b[p] = ($urandom_range(1) == 1) ? wr_addr : 5'($urandom_range(31));
    endtask

    task automatic chk_reset_zero(input string tag);
        for (int p = 0; p < 2; p++) begin
            chk({tag, "_a_data"}, {32'h0, rd_data_a[p]}, 64'h0);
            chk({tag, "_a_pend"}, {63'h0, rd_pend_a[p]}, 64'h0);
        end
        for (int p = 0; p < 4; p++) begin
            chk({tag, "_b_data"}, rd_data_b[p], 64'h0);
            chk({tag, "_b_pend"}, {63'h0, rd_pend_b[p]}, 64'h0);
        end
        chk({tag, "_a_any"}, {63'h0, any_a}, 64'h0);
        chk({tag, "_b_any"}, {63'h0, any_b}, 64'h0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    // Reference read: r0 is zero, a same-cycle write bypasses (A only), else storage.
    task automatic check_model();
        logic [4:0] a;
        logic       any;
        any = 1'b0;
        for (int i = 0; i < 32; i++) any |= m_pend[i];
        for (int p = 0; p < 2; p++) begin
            a = rd_addr_a[p];
            if (a == 0) begin
                chk("mdl_a_data", {32'h0, rd_data_a[p]}, 64'h0);
                chk("mdl_a_pend", {63'h0, rd_pend_a[p]}, 64'h0);
            end else if (wr_en && wr_addr == a) begin
                chk("mdl_a_data", {32'h0, rd_data_a[p]}, {32'h0, wr_data[31:0]});
                chk("mdl_a_pend", {63'h0, rd_pend_a[p]}, 64'h0);
            end else begin
                chk("mdl_a_data", {32'h0, rd_data_a[p]}, {32'h0, m_regs[a][31:0]});
                chk("mdl_a_pend", {63'h0, rd_pend_a[p]}, {63'h0, m_pend[a]});
            end
        end
        for (int p = 0; p < 4; p++) begin
            a = rd_addr_b[p];
            if (a == 0) begin
                chk("mdl_b_data", rd_data_b[p], 64'h0);
                chk("mdl_b_pend", {63'h0, rd_pend_b[p]}, 64'h0);
            end else begin
                chk("mdl_b_data", rd_data_b[p], m_regs[a]);
                chk("mdl_b_pend", {63'h0, rd_pend_b[p]}, {63'h0, m_pend[a]});
            end
        end
        chk("mdl_a_any", {63'h0, any_a}, {63'h0, any});
        chk("mdl_b_any", {63'h0, any_b}, {63'h0, any});
    endtask

    task automatic update_model();
        if (wr_en && wr_addr != 0) begin
            m_regs[wr_addr] = wr_data;
            m_pend[wr_addr] = 1'b0;
        end
        if (alloc_en && alloc_addr != 0 && !flush)
            m_pend[alloc_addr] = 1'b1;
        if (flush)
            for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    endtask

    // Inputs are already driven; check before the edge, then advance.
    task automatic tick();
        @(negedge clk);
        check_model();
        @(posedge clk);
        update_model();
        #1;
    endtask

    initial begin
        //          we    wa     wd                 ae    aa     fl    ra     exp_d          p     any
        vt[0]  = '{1'b0, 5'd0,  64'h0,             1'b0, 5'd0,  1'b0, 5'd5,  32'h0,         1'b0, 1'b0};
        vt[1]  = '{1'b1, 5'd3,  64'hDEADBEEF,      1'b0, 5'd0,  1'b0, 5'd3,  32'hDEADBEEF,  1'b0, 1'b0};
        vt[2]  = '{1'b0, 5'd0,  64'h0,             1'b0, 5'd0,  1'b0, 5'd3,  32'hDEADBEEF,  1'b0, 1'b0};
        vt[3]  = '{1'b1, 5'd0,  64'h1234,          1'b1, 5'd0,  1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
        vt[4]  = '{1'b0, 5'd0,  64'h0,             1'b0, 5'd0,  1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
        vt[5]  = '{1'b0, 5'd0,  64'h0,             1'b1, 5'd7,  1'b0, 5'd7,  32'h0,         1'b0, 1'b0};
        vt[6]  = '{1'b0, 5'd0,  64'h0,             1'b0, 5'd0,  1'b0, 5'd7,  32'h0,         1'b1, 1'b1};
        vt[7]  = '{1'b0, 5'd0,  64'h0,             1'b0, 5'd0,  1'b0, 5'd7,  32'h0,         1'b1, 1'b1};
        vt[8]  = '{1'b1, 5'd7,  64'h55,            1'b0, 5'd0,  1'b0, 5'd7,  32'h55,        1'b0, 1'b1};
        vt[9]  = '{1'b0, 5'd0,  64'h0,             1'b0, 5'd0,  1'b0, 5'd7,  32'h55,        1'b0, 1'b0};
        vt[10] = '{1'b1, 5'd9,  64'hA5,            1'b1, 5'd9,  1'b0, 5'd9,  32'hA5,        1'b0, 1'b0};
        vt[11] = '{1'b0, 5'd0,  64'h0,             1'b0, 5'd0,  1'b0, 5'd9,  32'hA5,        1'b1, 1'b1};
        vt[12] = '{1'b0, 5'd0,  64'h0,             1'b1, 5'd4,  1'b1, 5'd4,  32'h0,         1'b0, 1'b1};
        vt[13] = '{1'b0, 5'd0,  64'h0,             1'b0, 5'd0,  1'b0, 5'd9,  32'hA5,        1'b0, 1'b0};

        model_reset();

        // Reset with random inputs applied
        rst_n = 1'b0;
        randomize_inputs();
        #2;
        chk_reset_zero("rst_pre_edge");
        @(posedge clk);
        #1;
        randomize_inputs();
        #2;
        chk_reset_zero("rst_post_edge");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();

        // Directed table
        for (int i = 0; i < 14; i++) begin
            wr_en      = vt[i].we;
            wr_addr    = vt[i].wa;
            wr_data    = vt[i].wd;
            alloc_en   = vt[i].ae;
            alloc_addr = vt[i].aa;
            flush      = vt[i].fl;
            set_rd_all(vt[i].ra);
            @(negedge clk);
            chk($sformatf("vec%0d_data", i), {32'h0, rd_data_a[0]}, {32'h0, vt[i].exp_d});
            chk($sformatf("vec%0d_pend", i), {63'h0, rd_pend_a[0]}, {63'h0, vt[i].exp_p});
            chk($sformatf("vec%0d_any", i), {63'h0, any_a}, {63'h0, vt[i].exp_any});
            check_model();
            @(posedge clk);
            update_model();
            #1;
        end

        // Randomized traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            randomize_inputs();
            tick();
        end

        // No-bypass config: old value during the write cycle, new one after
        idle();
        wr_en   = 1'b1;
        wr_addr = 5'd2;
        wr_data = 64'h1111;
        tick();
        wr_data = 64'h0123456789ABCDEF;
        set_rd_all(5'd2);
        @(negedge clk);
        for (int p = 0; p < 4; p++) chk("nobyp_old", rd_data_b[p], 64'h1111);
        check_model();
        @(posedge clk);
        update_model();
        #1;
        idle();
        @(negedge clk);
        for (int p = 0; p < 4; p++) chk("nobyp_new", rd_data_b[p], 64'h0123456789ABCDEF);
        check_model();
        @(posedge clk);
        update_model();
        #1;

        // Reset asserted mid-write: immediate clear, write discarded
        wr_en      = 1'b1;
        wr_addr    = 5'd5;
        wr_data    = 64'hCAFEF00D_12345678;
        alloc_en   = 1'b1;
        alloc_addr = 5'd6;
        set_rd_all(5'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_zero("midrst_async");
        @(posedge clk);
        #1;
        chk_reset_zero("midrst_edge");
        model_reset();
        rst_n = 1'b1;
        idle();
        set_rd_all(5'd5);
        @(negedge clk);
        chk("midrst_r5_b", rd_data_b[0], 64'h0);
        chk("midrst_r5_a", {32'h0, rd_data_a[0]}, 64'h0);
        check_model();
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
